stream_check_sink: RTL and testbench

//  Downstream consumer for the packetised valid/ready test sources (sop/eop framed streams).
//  - Throttles o_ready with a rotating pattern, in the same style as the existing periodic sinks.
//  - Checks framing, packet length and a data-increment rule on every accepted beat.
//  - Counts packets and beats, and raises sticky error flags.
//  - Used as the terminating stage in protocol-sharing examples, so that interconnect

---
 rtl/stream_check_sink.sv | 174 +++++++++++++++++
 tb/tb_stream_check_sink.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_check_sink.sv
// stream_check_sink
//
// Terminating sink for sop/eop framed valid/ready streams. It throttles its
// ready output with a rotating pattern, checks every accepted beat for
// framing, packet length and a fixed data increment, counts beats and
// packets, and keeps sticky error flags.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous reset, active low
//   i_valid       upstream beat valid
//   o_ready       throttled ready (bit 0 of the rotate register)
//   i_data        beat data
//   i_sop/i_eop   start / end of packet markers
//   i_clr_err     synchronous clear of the sticky errors
//   o_pkt_count   completed packets (wraps)
//   o_beat_count  accepted beats (wraps)
//   o_last_len    length of the most recent completed packet (saturates at 255)
//   o_err         OR of o_err_code
//   o_err_code    sticky errors: [0] NOSOP, [1] SOP, [2] DATA, [3] LEN
//
// The length check assumes MAX_LEN < 255 so that the 8-bit length counter
// never saturates before an over-length packet has been detected.
module stream_check_sink #(
    parameter int                    WIDTH       = 16,
    parameter int                    RDY_PERIOD  = 3,
    parameter logic [RDY_PERIOD-1:0] RDY_PATTERN = 3'b001,
    parameter int                    STEP        = 1,
    parameter int                    MAX_LEN     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_sop,
    input  logic             i_eop,
    input  logic             i_clr_err,
    output logic [15:0]      o_pkt_count,
    output logic [15:0]      o_beat_count,
    output logic [7:0]       o_last_len,
    output logic             o_err,
    output logic [3:0]       o_err_code
);

    typedef enum logic {
        S_IDLE,
        S_PKT
    } state_t;

    localparam logic [3:0] ERR_NOSOP = 4'b0001;
    localparam logic [3:0] ERR_SOP   = 4'b0010;
    localparam logic [3:0] ERR_DATA  = 4'b0100;
    localparam logic [3:0] ERR_LEN   = 4'b1000;

    state_t                state_q, state_d;
    logic [RDY_PERIOD-1:0] rdy_q, rdy_d;
    logic [RDY_PERIOD:0]   rdy_ext;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic [WIDTH-1:0]      exp_data;
    logic [7:0]            len_q, len_d;
    logic [15:0]           pkt_q, pkt_d;
    logic [15:0]           beat_q, beat_d;
    logic [7:0]            last_q, last_d;
    logic [3:0]            err_q, err_d;
    logic                  err_any_q, err_any_d;
    logic [3:0]            err_new;
    logic                  xfer;

    // Saturating beat-length increment.
    function automatic logic [7:0] len_inc(input logic [7:0] len);
        return (len == 8'hFF) ? len : len + 8'd1;
    endfunction

    // True when adding one more beat to a packet of length len breaks MAX_LEN.
    function automatic logic len_over(input logic [7:0] len);
        return int'(len) >= MAX_LEN;
    endfunction

    always_comb begin
        xfer      = i_valid && rdy_q[0];

        // Rotate right: bit 0 wraps to the MSB. Written as a shift of the
        // extended vector so it also holds for a one-bit pattern.
        rdy_ext   = {rdy_q[0], rdy_q} >> 1;
        rdy_d     = rdy_ext[RDY_PERIOD-1:0];

        state_d   = state_q;
        prev_d    = prev_q;
        len_d     = len_q;
        pkt_d     = pkt_q;
        beat_d    = beat_q;
        last_d    = last_q;
        err_new   = 4'b0000;
        exp_data  = prev_q + WIDTH'(STEP);

        if (xfer) begin
            beat_d = beat_q + 16'd1;
            if (i_sop) begin
                // A sop inside a packet abandons it; the beat then starts a
                // fresh packet exactly as it would from IDLE.
                if (state_q == S_PKT) begin
                    err_new = err_new | ERR_SOP;
                end
                prev_d = i_data;
                len_d  = 8'd1;
                if (i_eop) begin
                    pkt_d   = pkt_q + 16'd1;
                    last_d  = 8'd1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PKT;
                end
            end else if (state_q == S_IDLE) begin
                // Orphan beat: counted as a beat but not checked.
                err_new = err_new | ERR_NOSOP;
            end else begin
                if (i_data != exp_data) begin
                    err_new = err_new | ERR_DATA;
                end
                if (len_over(len_q)) begin
                    err_new = err_new | ERR_LEN;
                end
                prev_d = i_data;
                len_d  = len_inc(len_q);
                if (i_eop) begin
                    pkt_d   = pkt_q + 16'd1;
                    last_d  = len_d;
                    state_d = S_IDLE;
                end
            end
        end

        // A clear and a new error in the same cycle leave the new bit set.
        err_d     = (i_clr_err ? 4'b0000 : err_q) | err_new;
        err_any_d = |err_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rdy_q     <= RDY_PATTERN;
            len_q     <= 8'd0;
            pkt_q     <= 16'd0;
            beat_q    <= 16'd0;
            last_q    <= 8'd0;
            err_q     <= 4'b0000;
            err_any_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            len_q     <= len_d;
            pkt_q     <= pkt_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            err_q     <= err_d;
            err_any_q <= err_any_d;
        end
    end

    // Previous-beat data is only meaningful inside a packet, and every packet
    // reloads it on its sop beat, so it needs no reset.
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
    end

    assign o_ready      = rdy_q[0];
    assign o_pkt_count  = pkt_q;
    assign o_beat_count = beat_q;
    assign o_last_len   = last_q;
    assign o_err        = err_any_q;
    assign o_err_code   = err_q;

endmodule

// File: tb/tb_stream_check_sink.sv
// Bench for stream_check_sink: two instances share one stimulus stream.
//   A: default parameters (ready 1 of every 3 cycles, MAX_LEN 16)
//   B: always ready, MAX_LEN 4
// A reference model tracks each instance from the framing rules and both are
// compared on every cycle; directed spot checks use literal values.
module tb_stream_check_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, i_sop, i_eop, i_clr_err;
    logic [15:0] i_data;

    logic        rdy_a, rdy_b, err_a, err_b;
    logic [15:0] pkt_a, pkt_b, beat_a, beat_b;
    logic [7:0]  last_a, last_b;
    logic [3:0]  code_a, code_b;

    always #5 clk = ~clk;

    stream_check_sink dut_a (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(rdy_a),
        .i_data(i_data), .i_sop(i_sop), .i_eop(i_eop), .i_clr_err(i_clr_err),
        .o_pkt_count(pkt_a), .o_beat_count(beat_a), .o_last_len(last_a),
        .o_err(err_a), .o_err_code(code_a)
    );

    stream_check_sink #(.RDY_PERIOD(1), .RDY_PATTERN(1'b1), .MAX_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(rdy_b),
        .i_data(i_data), .i_sop(i_sop), .i_eop(i_eop), .i_clr_err(i_clr_err),
        .o_pkt_count(pkt_b), .o_beat_count(beat_b), .o_last_len(last_b),
        .o_err(err_b), .o_err_code(code_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_ph;          // active edges since reset
    int          m_len   [2];   // beats in the open packet, 0 = no packet open
    logic [15:0] m_prev  [2];
    logic [15:0] m_pkt   [2];
    logic [15:0] m_beat  [2];
    logic [7:0]  m_last  [2];
    logic [3:0]  m_err   [2];
    int          max_len [2] = '{16, 4};

    // Pattern 3'b001 rotating right presents 1,0,0,1,0,0... on bit 0.
    function automatic bit m_ready(input int k);
        return (k == 1) || (m_ph % 3 == 0);
    endfunction

    task automatic model_reset();
        m_ph = 0;
        for (int k = 0; k < 2; k++) begin
            m_len[k] = 0; m_prev[k] = '0; m_pkt[k] = '0;
            m_beat[k] = '0; m_last[k] = '0; m_err[k] = '0;
        end
    endtask

    task automatic model_beat(input int k);
        m_beat[k] = m_beat[k] + 16'd1;
        if (i_sop) begin
            if (m_len[k] != 0) m_err[k][1] = 1'b1;
            m_len[k]  = 1;
            m_prev[k] = i_data;
        end else if (m_len[k] == 0) begin
            m_err[k][0] = 1'b1;
        end else begin
            if (i_data != 16'(m_prev[k] + 16'd1)) m_err[k][2] = 1'b1;
            m_prev[k] = i_data;
            m_len[k]++;
            if (m_len[k] > max_len[k]) m_err[k][3] = 1'b1;
        end
        if (i_eop && m_len[k] != 0) begin
            m_pkt[k]  = m_pkt[k] + 16'd1;
            m_last[k] = (m_len[k] > 255) ? 8'd255 : 8'(m_len[k]);
            m_len[k]  = 0;
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (i_clr_err) m_err[k] = 4'b0000;
                if (i_valid && m_ready(k)) model_beat(k);
            end
            m_ph++;
        end
    endtask

    task automatic compare_all();
        check_eq("a_ready", {31'd0, rdy_a}, {31'd0, m_ready(0)});
        check_eq("a_pkt",   {16'd0, pkt_a},  {16'd0, m_pkt[0]});
        check_eq("a_beat",  {16'd0, beat_a}, {16'd0, m_beat[0]});
        check_eq("a_last",  {24'd0, last_a}, {24'd0, m_last[0]});
        check_eq("a_code",  {28'd0, code_a}, {28'd0, m_err[0]});
        check_eq("a_err",   {31'd0, err_a},  {31'd0, |m_err[0]});
        check_eq("b_ready", {31'd0, rdy_b}, {31'd0, m_ready(1)});
        check_eq("b_pkt",   {16'd0, pkt_b},  {16'd0, m_pkt[1]});
        check_eq("b_beat",  {16'd0, beat_b}, {16'd0, m_beat[1]});
        check_eq("b_last",  {24'd0, last_b}, {24'd0, m_last[1]});
        check_eq("b_code",  {28'd0, code_b}, {28'd0, m_err[1]});
        check_eq("b_err",   {31'd0, err_b},  {31'd0, |m_err[1]});
    endtask

    // Called at a falling edge with inputs already set.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clr();
        i_valid = 1'b0; i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
    endtask

    // Present one beat on a cycle where A is ready, so A and B accept it alike.
    task automatic send(input logic [15:0] d, input logic s, input logic e);
        i_clr_err = 1'b0;
        i_valid   = 1'b0;
        for (int g = 0; g < 4 && !m_ready(0); g++) tick();
        i_valid = 1'b1; i_data = d; i_sop = s; i_eop = e;
        tick();
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    endtask

    int          plen;
    logic [15:0] base;
    bit          nosop;

    initial begin
        reset = 1'b0; i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        i_clr_err = 1'b0; i_data = '0;
        model_reset();
        @(negedge clk);
        repeat (3) tick();
        check_eq("rst_ready", {31'd0, rdy_a}, 32'd1);
        check_eq("rst_pkt",   {16'd0, pkt_a}, 32'd0);
        check_eq("rst_code",  {28'd0, code_a}, 32'd0);
        reset = 1'b1;

        // Throttle: valid held high, A accepts one beat every third cycle.
        i_valid = 1'b1; i_sop = 1'b0; i_eop = 1'b0;
        for (int i = 0; i < 9; i++) begin
            i_data = 16'($urandom);
            tick();
        end
        check_eq("t1_beat_a", {16'd0, beat_a}, 32'd3);
        check_eq("t1_beat_b", {16'd0, beat_b}, 32'd9);
        check_eq("t1_nosop",  {28'd0, code_a}, 32'h1);
        clr();

        // Clean 5-beat packet; over length on B only.
        send(16'd1, 1'b1, 1'b0);
        for (int i = 2; i <= 4; i++) send(16'(i), 1'b0, 1'b0);
        send(16'd5, 1'b0, 1'b1);
        check_eq("t2_pkt",  {16'd0, pkt_a}, 32'd1);
        check_eq("t2_len",  {24'd0, last_a}, 32'd5);
        check_eq("t2_code", {28'd0, code_a}, 32'h0);
        check_eq("t2_code_b", {28'd0, code_b}, 32'h8);
        clr();

        // Data increment broken.
        send(16'd1, 1'b1, 1'b0);
        send(16'd2, 1'b0, 1'b0);
        send(16'd4, 1'b0, 1'b1);
        check_eq("t3_data", {28'd0, code_a}, 32'h4);
        check_eq("t3_pkt",  {16'd0, pkt_a}, 32'd2);
        clr();
        check_eq("t3_clr",  {28'd0, code_a}, 32'h0);

        // Orphan beat, then sop inside a packet.
        send(16'd7, 1'b0, 1'b0);
        check_eq("t4_nosop", {28'd0, code_a}, 32'h1);
        clr();
        send(16'd10, 1'b1, 1'b0);
        send(16'd11, 1'b0, 1'b0);
        send(16'd20, 1'b1, 1'b0);
        send(16'd21, 1'b0, 1'b0);
        send(16'd22, 1'b0, 1'b1);
        check_eq("t4_sop",  {28'd0, code_a}, 32'h2);
        check_eq("t4_pkt",  {16'd0, pkt_a}, 32'd3);
        check_eq("t4_len",  {24'd0, last_a}, 32'd3);
        clr();

        // 6-beat packet against MAX_LEN 4 (B) and 16 (A), then single-beat.
        send(16'd30, 1'b1, 1'b0);
        for (int i = 31; i <= 34; i++) send(16'(i), 1'b0, 1'b0);
        send(16'd35, 1'b0, 1'b1);
        check_eq("t5_len_b",  {28'd0, code_b}, 32'h8);
        check_eq("t5_last_b", {24'd0, last_b}, 32'd6);
        check_eq("t5_code_a", {28'd0, code_a}, 32'h0);
        clr();
        send(16'd40, 1'b1, 1'b1);
        check_eq("t5_single", {24'd0, last_b}, 32'd1);
        check_eq("t5_pkt_b",  {16'd0, pkt_b}, 32'd5);
        send(16'd41, 1'b0, 1'b0);
        check_eq("t5_idle",   {28'd0, code_b}, 32'h1);
        clr();

        // Random packets, ignoring ready so A and B see different beats.
        for (int p = 0; p < 80; p++) begin
            plen  = $urandom_range(1, 7);
            base  = 16'($urandom);
            nosop = ($urandom_range(0, 9) == 0);
            for (int b = 0; b < plen; b++) begin
                i_valid   = ($urandom_range(0, 3) != 0);
                i_sop     = ((b == 0) && !nosop) || ($urandom_range(0, 19) == 0);
                i_eop     = (b == plen - 1);
                i_data    = base + 16'(b);
                if ($urandom_range(0, 9) == 0) i_data = i_data ^ 16'h0010;
                i_clr_err = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_clr_err = 1'b0;

        // Reset mid-packet.
        send(16'd100, 1'b1, 1'b0);
        send(16'd101, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check_eq("t6_rst_pkt",  {16'd0, pkt_a}, 32'd0);
        check_eq("t6_rst_beat", {16'd0, beat_a}, 32'd0);
        check_eq("t6_rst_rdy",  {31'd0, rdy_a}, 32'd1);
        reset = 1'b1;
        send(16'd200, 1'b1, 1'b0);
        send(16'd201, 1'b0, 1'b0);
        send(16'd202, 1'b0, 1'b1);
        check_eq("t6_pkt",  {16'd0, pkt_a}, 32'd1);
        check_eq("t6_code", {28'd0, code_a}, 32'h0);
        check_eq("t6_len",  {24'd0, last_a}, 32'd3);

        // Beat counter wrap: 65536 single-beat packets into B.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        i_valid = 1'b1; i_sop = 1'b1; i_eop = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            i_data = 16'(i);
            tick();
        end
        i_valid = 1'b0;
        check_eq("wrap_beat_b", {16'd0, beat_b}, 32'd0);
        check_eq("wrap_pkt_b",  {16'd0, pkt_b}, 32'd0);
        check_eq("wrap_beat_a", {16'd0, beat_a}, 32'd21846);
        check_eq("wrap_code_b", {28'd0, code_b}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
